// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
//   instructions : decoded instruction flags produced upstream
//   mem_state_t  : access FSM states
//   STRB_*       : base byte-enable patterns for byte/half/word stores
//   helpers      : opcode classification, alignment and store-lane encoding
package mem_access_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic add;
        logic sub;
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
    } instructions;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    function automatic logic is_load(input instructions i);
        return i.lb | i.lh | i.lw | i.lbu | i.lhu;
    endfunction

    function automatic logic is_store(input instructions i);
        return i.sb | i.sh | i.sw;
    endfunction

    function automatic logic is_mem(input instructions i);
        return is_load(i) | is_store(i);
    endfunction

    // Halfwords need bit 0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input instructions i, input logic [1:0] a);
        return ((i.lh | i.lhu | i.sh) & a[0]) | ((i.lw | i.sw) & (a != 2'b00));
    endfunction

    function automatic logic [3:0] store_strb(input instructions i, input logic [1:0] a);
        logic [3:0] s;
        s = 4'b0000;
        if (i.sb)      s = STRB_B << a;
        else if (i.sh) s = a[1] ? (STRB_H << 2) : STRB_H;
        else if (i.sw) s = STRB_W;
        return s;
    endfunction

    // Data is replicated across lanes so the strobes alone select the bytes.
    function automatic logic [XLEN-1:0] store_data(input instructions i, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        w = d;
        if (i.sb)      w = {4{d[7:0]}};
        else if (i.sh) w = {2{d[15:0]}};
        return w;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Single-outstanding valid/ready memory port.
//   master : the access stage (drives request, receives response)
//   slave  : the memory (accepts request, returns rvalid/rdata)
interface mem_access_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  mem_req_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output mem_req_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_access_load_formatter.sv
// Aligns the addressed byte/halfword of a read word and sign/zero-extends it.
//   rdata            : raw word from memory
//   addr             : byte offset within the word
//   lb/lh/lw/lbu/lhu : load kind (one-hot)
//   data             : formatted load value
module load_formatter (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic        lb,
    input  logic        lh,
    input  logic        lw,
    input  logic        lbu,
    input  logic        lhu,
    output logic [31:0] data
);
    logic [15:0] lane;

    // Only the low halfword of the shifted word is ever consumed.
    assign lane = 16'(rdata >> {addr, 3'b000});

    always_comb begin
        // NOTE: default first so every path assigns data; otherwise a latch is inferred.
        data = '0;
        if (lw)       data = rdata;
        else if (lh)  data = {{16{lane[15]}}, lane};
        else if (lhu) data = {16'h0000, lane};
        else if (lb)  data = {{24{lane[7]}}, lane[7:0]};
        else if (lbu) data = {24'h000000, lane[7:0]};
    end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage behind the execute ALU.
//   clk, rstn          : clock, async active-low reset
//   enabled            : one-cycle start strobe (ignored while busy)
//   instr              : decoded instruction flags
//   alu_result         : effective address or value to forward
//   rs2                : store data
//   busy               : access in progress
//   completed          : one-cycle result-valid pulse
//   result             : load data / forwarded value / faulting address
//   misaligned         : qualifies completed; access was not naturally aligned
//   mem                : memory port (master side)
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enabled,
    input  instructions     instr,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            completed,
    output logic [XLEN-1:0] result,
    output logic            misaligned,
    mem_access_if.master    mem
);
    mem_state_t      state_q, state_d;
    instructions     instr_q;
    logic [XLEN-1:0] addr_q;
    logic [3:0]      wstrb_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] result_q;
    logic            mis_q;
    logic [XLEN-1:0] load_data;
    logic            accept;
    logic            go_mem;
    logic            unused_flags;

    assign accept = (state_q == IDLE) && enabled;
    assign go_mem = is_mem(instr) && !is_misaligned(instr, alu_result[1:0]);

    // ALU-only flags are carried in the latched struct but never decoded here.
    assign unused_flags = ^{instr_q.add, instr_q.sub};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enabled) state_d = go_mem ? REQ : DONE;
            REQ:     if (mem.mem_req_ready) state_d = WAIT;
            WAIT:    if (mem.mem_rvalid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; reset forces IDLE so the request drops at once.
    always_comb begin
        busy              = (state_q != IDLE);
        completed         = (state_q == DONE);
        misaligned        = (state_q == DONE) && mis_q;
        mem.mem_req_valid = (state_q == REQ);
    end

    load_formatter u_load_formatter (
        .rdata (mem.mem_rdata),
        .addr  (addr_q[1:0]),
        .lb    (instr_q.lb),
        .lh    (instr_q.lh),
        .lw    (instr_q.lw),
        .lbu   (instr_q.lbu),
        .lhu   (instr_q.lhu),
        .data  (load_data)
    );

    // Operand capture and result register. Request fields are captured once at
    // accept, so they cannot move while the request is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instr_q  <= '0;
            addr_q   <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            if (accept) begin
                instr_q <= instr;
                addr_q  <= alu_result;
                wstrb_q <= store_strb(instr, alu_result[1:0]);
                wdata_q <= store_data(instr, rs2);
                if (!go_mem) begin
                    result_q <= alu_result;
                    mis_q    <= is_misaligned(instr, alu_result[1:0]);
                end
            end
            if (state_q == WAIT && mem.mem_rvalid) begin
                result_q <= is_store(instr_q) ? '0 : load_data;
                mis_q    <= 1'b0;
            end
        end
    end

    assign result        = result_q;
    assign mem.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem.mem_we    = is_store(instr_q);
    assign mem.mem_wstrb = wstrb_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a spec-level model and per-cycle compare.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0;
    instructions instr = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] rs2 = '0;
    logic        busy, completed, misaligned;
    logic [31:0] result;

    mem_access_if mem_bus ();

    mem_access dut (
        .clk        (clk),
        .rstn       (rstn),
        .enabled    (enabled),
        .instr      (instr),
        .alu_result (alu_result),
        .rs2        (rs2),
        .busy       (busy),
        .completed  (completed),
        .result     (result),
        .misaligned (misaligned),
        .mem        (mem_bus.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // One expected access: edge that samples enabled, edge after which
    // completed is high, window of edges with request valid.
    typedef struct {
        int          start;
        int          due;
        int          req_lo;
        int          req_hi;
        logic [31:0] res;
        logic        mis;
    } exp_t;
    exp_t q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- specification-level model ----------------
    function automatic int access_bytes(input instructions i);
        if (i.lw || i.sw) return 4;
        if (i.lh || i.lhu || i.sh) return 2;
        if (i.lb || i.lbu || i.sb) return 1;
        return 0;
    endfunction

    function automatic logic model_mis(input instructions i, input logic [31:0] a);
        int sz;
        sz = access_bytes(i);
        return (sz > 1) && ((a % sz) != 0);
    endfunction

    function automatic logic model_store(input instructions i);
        return i.sb || i.sh || i.sw;
    endfunction

    function automatic logic [31:0] model_result(input instructions i, input logic [31:0] a,
                                                 input logic [31:0] rd);
        int sz;
        logic [31:0] v, mask;
        sz = access_bytes(i);
        if (sz == 0 || model_mis(i, a)) return a;
        if (model_store(i)) return 32'h0;
        v = rd >> (8 * (a % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        v = v & mask;
        if ((i.lb || i.lh) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input instructions i, input logic [31:0] a);
        int sz;
        sz = access_bytes(i);
        if (!model_store(i)) return 4'b0000;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input instructions i, input logic [31:0] d);
        int sz;
        logic [31:0] w;
        sz = access_bytes(i);
        w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % sz) +: 8];
        return w;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic have, exp_c, exp_b, exp_v;
        if (rstn) begin
            have  = (q.size() > 0);
            exp_c = have && (q[0].due == edge_n);
            exp_b = have && (edge_n >= q[0].start) && (edge_n <= q[0].due);
            exp_v = have && (edge_n >= q[0].req_lo) && (edge_n <= q[0].req_hi);
            check("completed", completed, exp_c);
            check("busy", busy, exp_b);
            check("mem_req_valid", mem_bus.mem_req_valid, exp_v);
            if (exp_c) begin
                check("result", result, q[0].res);
                check("misaligned", misaligned, q[0].mis);
                void'(q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_fields(input string nm, input instructions i,
                                input logic [31:0] a, input logic [31:0] d);
        check({nm, ".addr"}, mem_bus.mem_addr, {a[31:2], 2'b00});
        check({nm, ".we"}, mem_bus.mem_we, model_store(i));
        check({nm, ".wstrb"}, mem_bus.mem_wstrb, model_strb(i, a));
        if (model_store(i)) check({nm, ".wdata"}, mem_bus.mem_wdata, model_wdata(i, d));
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (q.size() > 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            check({nm, ".timeout"}, 32'd0, 32'd1);
            q.delete();
        end
    endtask

    task automatic do_op(input string nm, input instructions ins, input logic [31:0] a,
                         input logic [31:0] d, input int rstall, input int vstall,
                         input logic [31:0] rd, input logic [31:0] lit, input logic poke);
        exp_t e;
        logic go;
        int   s;
        instructions alu_op;
        go = (access_bytes(ins) != 0) && !model_mis(ins, a);
        @(negedge clk);
        instr = ins; alu_result = a; rs2 = d; enabled = 1'b1;
        s = edge_n + 1;
        e.start = s;
        e.res   = model_result(ins, a, rd);
        e.mis   = model_mis(ins, a);
        if (go) begin
            e.req_lo = s; e.req_hi = s + rstall; e.due = s + 2 + rstall + vstall;
        end else begin
            e.req_lo = 1; e.req_hi = 0; e.due = s;
        end
        q.push_back(e);
        @(negedge clk);
        enabled = 1'b0; instr = '0;
        if (go) begin
            for (int i = 0; i < rstall; i++) begin
                check_fields(nm, ins, a, d);
                if (poke && i == 0) begin
                    alu_op = '0; alu_op.add = 1'b1;
                    instr = alu_op; alu_result = 32'hDEAD_0000; rs2 = 32'h1111_1111;
                    enabled = 1'b1;
                end
                @(negedge clk);
                enabled = 1'b0; instr = '0;
            end
            check_fields(nm, ins, a, d);
            mem_bus.mem_req_ready = 1'b1;
            @(negedge clk);
            mem_bus.mem_req_ready = 1'b0;
            repeat (vstall) @(negedge clk);
            mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rd;
            @(negedge clk);
            mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h5A5A_5A5A;
        end
        wait_idle(nm);
        @(negedge clk);
        check({nm, ".held"}, result, lit);
    endtask

    function automatic instructions op(input string n);
        instructions i;
        i = '0;
        case (n)
            "add": i.add = 1'b1;
            "lb":  i.lb  = 1'b1;
            "lh":  i.lh  = 1'b1;
            "lw":  i.lw  = 1'b1;
            "lbu": i.lbu = 1'b1;
            "lhu": i.lhu = 1'b1;
            "sb":  i.sb  = 1'b1;
            "sh":  i.sh  = 1'b1;
            "sw":  i.sw  = 1'b1;
            default: i = '0;
        endcase
        return i;
    endfunction

    initial begin
        exp_t e;
        int   s;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rvalid    = 1'b0;
        mem_bus.mem_rdata     = '0;

        #3;
        check("rst.busy", busy, 1'b0);
        check("rst.completed", completed, 1'b0);
        check("rst.result", result, 32'h0);
        check("rst.req_valid", mem_bus.mem_req_valid, 1'b0);
        check("rst.addr", mem_bus.mem_addr, 32'h0);
        check("rst.wstrb", mem_bus.mem_wstrb, 4'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        //    name   op         addr           rs2            rst vst rdata          literal        poke
        do_op("add", op("add"), 32'h0000_1234, 32'h0,         0,  0,  32'h0,         32'h0000_1234, 1'b0);
        do_op("lb",  op("lb"),  32'h0000_1003, 32'h0,         0,  0,  32'h80AA_BBCC, 32'hFFFF_FF80, 1'b0);
        do_op("lhu", op("lhu"), 32'h0000_2002, 32'h0,         2,  0,  32'h8001_7FFF, 32'h0000_8001, 1'b1);
        do_op("sb",  op("sb"),  32'h0000_3001, 32'h0000_00A5, 0,  0,  32'h0,         32'h0,         1'b0);
        do_op("sw",  op("sw"),  32'h0000_4002, 32'hFFFF_FFFF, 0,  0,  32'h0,         32'h0000_4002, 1'b0);
        do_op("sh",  op("sh"),  32'h0000_3002, 32'h1234_BEEF, 1,  1,  32'h0,         32'h0,         1'b0);
        do_op("lh",  op("lh"),  32'h0000_2000, 32'h0,         0,  2,  32'h1234_8765, 32'hFFFF_8765, 1'b0);
        do_op("lw",  op("lw"),  32'h0000_6000, 32'h0,         0,  0,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
        do_op("lhm", op("lh"),  32'h0000_2001, 32'h0,         0,  0,  32'h0,         32'h0000_2001, 1'b0);
        do_op("lbu", op("lbu"), 32'h0000_1002, 32'h0,         0,  0,  32'h80AA_BBCC, 32'h0000_00AA, 1'b0);
        do_op("swa", op("sw"),  32'h0000_7000, 32'h0102_0304, 0,  0,  32'h0,         32'h0,         1'b0);

        // Reset while a load waits for its response; a late response must be dropped.
        @(negedge clk);
        instr = op("lw"); alu_result = 32'h0000_5004; enabled = 1'b1;
        s = edge_n + 1;
        e.start = s; e.due = s + 100; e.req_lo = s; e.req_hi = s;
        e.res = 32'h0; e.mis = 1'b0;
        q.push_back(e);
        @(negedge clk);
        enabled = 1'b0; instr = '0;
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_req_ready = 1'b0;
        #2 rstn = 1'b0;
        q.delete();
        #1;
        check("mid.busy", busy, 1'b0);
        check("mid.completed", completed, 1'b0);
        check("mid.result", result, 32'h0);
        check("mid.misaligned", misaligned, 1'b0);
        check("mid.req_valid", mem_bus.mem_req_valid, 1'b0);
        check("mid.addr", mem_bus.mem_addr, 32'h0);
        check("mid.we", mem_bus.mem_we, 1'b0);
        check("mid.wstrb", mem_bus.mem_wstrb, 4'h0);
        check("mid.wdata", mem_bus.mem_wdata, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("late.result", result, 32'h0);

        do_op("lw2", op("lw"), 32'h0000_5004, 32'h0, 0, 0, 32'h0BAD_BEEF, 32'h0BAD_BEEF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
